// File: rtl/flash_arbiter.sv
// Two-requester read arbiter in front of the single flash Avalon-MM read port; one read outstanding at a time.
// Latency: request in IDLE -> flash_mem_read next cycle; readdatavalid is forwarded combinationally in its arrival cycle.
// Backpressure: flash_mem_waitrequest extends ISSUE indefinitely; the losing requester is held with waitrequest high.
//
// Ports:
//   clk, rst_n                  system clock, synchronous active-low reset
//   rN_read / rN_address        requester N read strobe and word address (held until rN_waitrequest is low)
//   rN_waitrequest              low for exactly one cycle when requester N's read is accepted by flash
//   rN_readdatavalid/readdata   one-cycle data pulse, routed only to the requester that issued the read
//   flash_mem_*                 master side toward the flash read port
//   busy                        high whenever a transaction is in progress
//
// Build option: define FLASH_ARB_RR_EN for round-robin between the two requesters;
// otherwise r0 has fixed priority.
module flash_arbiter #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_read,
    input  logic [ADDR_W-1:0] r0_address,
    output logic              r0_waitrequest,
    output logic              r0_readdatavalid,
    output logic [DATA_W-1:0] r0_readdata,
    input  logic              r1_read,
    input  logic [ADDR_W-1:0] r1_address,
    output logic              r1_waitrequest,
    output logic              r1_readdatavalid,
    output logic [DATA_W-1:0] r1_readdata,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_grant;      // requester owning the current transaction
    logic                w_grant_nxt;
    logic                r_last;       // requester served most recently
    logic                w_last_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_win;        // arbitration winner, meaningful only when some read is high

    // Winner selection. With only one requester active it simply wins;
    // the policy only matters when both are requesting.
    always_comb begin
`ifdef FLASH_ARB_RR_EN
        if (r0_read && r1_read) begin
            w_win = ~r_last;
        end else begin
            w_win = ~r0_read;
        end
`else
        w_win = ~r0_read;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;   // so r0 is the first round-robin winner
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_nxt       = r_last;
        w_addr_nxt       = r_addr;
        flash_mem_read   = 1'b0;
        r0_waitrequest   = 1'b1;
        r1_waitrequest   = 1'b1;
        r0_readdatavalid = 1'b0;
        r1_readdatavalid = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Late or stray flash data is dropped here simply by not forwarding it.
                if (r0_read || r1_read) begin
                    w_grant_nxt = w_win;
                    w_addr_nxt  = w_win ? r1_address : r0_address;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                flash_mem_read = 1'b1;
                if (!flash_mem_waitrequest) begin
                    // The owner's waitrequest mirrors the flash acceptance in the same cycle.
                    r0_waitrequest = r_grant;
                    r1_waitrequest = ~r_grant;
                    w_state_nxt    = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    r0_readdatavalid = ~r_grant;
                    r1_readdatavalid = r_grant;
                    w_last_nxt       = r_grant;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign flash_mem_address = r_addr;
    assign r0_readdata       = flash_mem_readdata;
    assign r1_readdata       = flash_mem_readdata;
    assign busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: directed cycle tables, a reset-during-read sequence,
// a 128-read sequential load and a randomized two-requester run against a
// transaction-level model of the arbitration rules.
module tb_flash_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;
`ifdef FLASH_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_read, r1_read;
    logic [AW-1:0] r0_address, r1_address;
    logic          r0_waitrequest, r1_waitrequest;
    logic          r0_readdatavalid, r1_readdatavalid;
    logic [DW-1:0] r0_readdata, r1_readdata;
    logic          flash_mem_read;
    logic [AW-1:0] flash_mem_address;
    logic          flash_mem_waitrequest;
    logic [DW-1:0] flash_mem_readdata;
    logic          flash_mem_readdatavalid;
    logic          busy;

    flash_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .r0_read                 (r0_read),
        .r0_address              (r0_address),
        .r0_waitrequest          (r0_waitrequest),
        .r0_readdatavalid        (r0_readdatavalid),
        .r0_readdata             (r0_readdata),
        .r1_read                 (r1_read),
        .r1_address              (r1_address),
        .r1_waitrequest          (r1_waitrequest),
        .r1_readdatavalid        (r1_readdatavalid),
        .r1_readdata             (r1_readdata),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          rs;
        logic          r0r;
        logic [AW-1:0] r0a;
        logic          r1r;
        logic [AW-1:0] r1a;
        logic          fw;
        logic          fv;
        logic [31:0]   fd;
        logic          efr;
        logic [AW-1:0] efa;
        logic          e0w;
        logic          e1w;
        logic          e0v;
        logic          e1v;
        logic          eb;
        string         nm;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] fdat(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {9'd0, a};
        return w * 32'h0001_0001;
    endfunction

    function void add(input int rs, input int r0r, input int r0a, input int r1r, input int r1a,
                      input int fw, input int fv, input int fd,
                      input int efr, input int efa, input int e0w, input int e1w,
                      input int e0v, input int e1v, input int eb, input string nm);
        vec_t v;
        v.rs  = (rs != 0);   v.r0r = (r0r != 0);  v.r0a = AW'(r0a);
        v.r1r = (r1r != 0);  v.r1a = AW'(r1a);
        v.fw  = (fw != 0);   v.fv  = (fv != 0);   v.fd  = 32'(fd);
        v.efr = (efr != 0);  v.efa = AW'(efa);
        v.e0w = (e0w != 0);  v.e1w = (e1w != 0);
        v.e0v = (e0v != 0);  v.e1v = (e1v != 0);  v.eb = (eb != 0);
        v.nm  = nm;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One clock cycle: drive after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic rs, input logic r0r, input logic [AW-1:0] r0a,
                       input logic r1r, input logic [AW-1:0] r1a,
                       input logic fw, input logic fv, input logic [31:0] fd);
        @(posedge clk);
        #1;
        rst_n = rs;
        r0_read = r0r;  r0_address = r0a;
        r1_read = r1r;  r1_address = r1a;
        flash_mem_waitrequest   = fw;
        flash_mem_readdatavalid = fv;
        flash_mem_readdata      = fd;
        @(negedge clk);
    endtask

    function automatic logic [63:0] dut_outs();
        return 64'({flash_mem_read, flash_mem_address, r0_waitrequest, r1_waitrequest,
                    r0_readdatavalid, r1_readdatavalid, busy});
    endfunction

    // Transaction-level model state for the sequential/random runs.
    logic          mreq [2];
    logic [AW-1:0] maddr[2];
    bit            m_free;
    int            m_owner;
    bit            m_acc;
    int            m_last;
    logic [AW-1:0] m_addr;
    logic [31:0]   q0[$];
    logic [31:0]   q1[$];
    int            pend_cnt;
    logic [31:0]   pend_dat;
    int            seq_next;
    int            pulses0, pulses1;

    task automatic engine(input bit load, input int ncyc);
        int          cnt = 0;
        int          w;
        logic        fw, fv, e_iss, e0w, e1w, e0v, e1v;
        logic [31:0] fd;
        logic [31:0] ex;
        seq_next = 0;
        pulses0  = 0;
        pulses1  = 0;
        while (cnt < ncyc) begin
            if (load && seq_next == 128 && m_free && q0.size() == 0 && !mreq[0]) break;
            cnt++;
            for (int n = 0; n < 2; n++) begin
                if (!mreq[n]) begin
                    if (load) begin
                        if (n == 0 && seq_next < 128) begin
                            mreq[0]  = 1'b1;
                            maddr[0] = AW'(seq_next);
                            seq_next++;
                        end
                    end else if ($urandom_range(0, 2) == 0) begin
                        mreq[n]  = 1'b1;
                        maddr[n] = AW'($urandom);
                    end
                end
            end
            fw = ($urandom_range(0, 3) == 0);
            fv = 1'b0;
            fd = $urandom;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    fv = 1'b1;
                    fd = pend_dat;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                fv = 1'b1;   // stray data while nothing is outstanding
            end
            cyc(1'b1, mreq[0], maddr[0], mreq[1], maddr[1], fw, fv, fd);

            e_iss = !m_free && !m_acc;
            e0w   = !(e_iss && m_owner == 0 && !fw);
            e1w   = !(e_iss && m_owner == 1 && !fw);
            e0v   = !m_free && m_acc && m_owner == 0 && fv;
            e1v   = !m_free && m_acc && m_owner == 1 && fv;
            check(load ? "load_outs" : "rand_outs", dut_outs(),
                  64'({e_iss, m_addr, e0w, e1w, e0v, e1v, !m_free}));
            if (r0_readdatavalid) pulses0++;
            if (r1_readdatavalid) pulses1++;
            if (e0v) begin
                ex = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
                check("r0_data", 64'(r0_readdata), 64'(ex));
            end
            if (e1v) begin
                ex = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
                check("r1_data", 64'(r1_readdata), 64'(ex));
            end

            // Flash slave: schedule data for whatever address it actually saw.
            if (flash_mem_read && !fw) begin
                pend_cnt = $urandom_range(1, 4);
                pend_dat = fdat(flash_mem_address);
            end

            // Model: free -> pick winner; granted -> accepted on no stall; accepted -> done on data.
            if (m_free) begin
                if (mreq[0] || mreq[1]) begin
                    if (mreq[0] && mreq[1]) w = RR ? ((m_last == 0) ? 1 : 0) : 0;
                    else                    w = mreq[0] ? 0 : 1;
                    m_owner = w;
                    m_addr  = maddr[w];
                    m_free  = 1'b0;
                    m_acc   = 1'b0;
                end
            end else if (!m_acc) begin
                if (!fw) begin
                    m_acc = 1'b1;
                    if (m_owner == 0) q0.push_back(fdat(maddr[0]));
                    else              q1.push_back(fdat(maddr[1]));
                    mreq[m_owner] = 1'b0;
                end
            end else if (fv) begin
                m_last = m_owner;
                m_free = 1'b1;
            end
        end
        if (load) begin
            check("load_complete", 64'(seq_next == 128 && m_free && q0.size() == 0), 64'd1);
            check("load_r0_pulses", 64'(pulses0), 64'd128);
            check("load_r1_pulses", 64'(pulses1), 64'd0);
        end else begin
            check("rand_r0_pulses_vs_model", 64'(pulses0 > 0), 64'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end

    initial begin
        int w;
        int a;
        int pa;

        rst_n = 1'b0;
        r0_read = 1'b0;  r0_address = '0;
        r1_read = 1'b0;  r1_address = '0;
        flash_mem_waitrequest = 1'b0;
        flash_mem_readdata = '0;
        flash_mem_readdatavalid = 1'b0;

        // rs r0r r0a r1r r1a fw fv fd | efr efa e0w e1w e0v e1v eb
        add(1, 0, 0, 0, 0, 0, 0, 0,              0, 0,     1, 1, 0, 0, 0, "reset_vals");
        add(1, 0, 0, 0, 0, 0, 1, 32'h1111_1111,  0, 0,     1, 1, 0, 0, 0, "idle_stray");
        // single r0 read, data three cycles after accept
        add(1, 1, 'h10, 0, 0, 0, 0, 0,           0, 0,     1, 1, 0, 0, 0, "s_req");
        add(1, 1, 'h10, 0, 0, 0, 0, 0,           1, 'h10,  0, 1, 0, 0, 1, "s_acc");
        add(1, 0, 0, 0, 0, 0, 0, 0,              0, 'h10,  1, 1, 0, 0, 1, "s_wait1");
        add(1, 0, 0, 0, 0, 0, 0, 0,              0, 'h10,  1, 1, 0, 0, 1, "s_wait2");
        add(1, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF,  0, 'h10,  1, 1, 1, 0, 1, "s_data");
        add(1, 0, 0, 0, 0, 0, 0, 0,              0, 'h10,  1, 1, 0, 0, 0, "s_done");
        // five stall cycles; address change after grant is ignored; stray data dropped
        add(1, 1, 'h55, 0, 0, 0, 0, 0,           0, 'h10,  1, 1, 0, 0, 0, "st_req");
        for (int k = 0; k < 5; k++)
            add(1, 1, (k == 0) ? 'h55 : 'h66, 0, 0, 1, (k == 2) ? 1 : 0, 32'h0BAD_0BAD,
                1, 'h55, 1, 1, 0, 0, 1, "st_hold");
        add(1, 1, 'h66, 0, 0, 0, 0, 0,           1, 'h55,  0, 1, 0, 0, 1, "st_acc");
        add(1, 0, 0, 0, 0, 0, 0, 0,              0, 'h55,  1, 1, 0, 0, 1, "st_wait");
        add(1, 0, 0, 0, 0, 0, 1, 32'h1234_5678,  0, 'h55,  1, 1, 1, 0, 1, "st_data");
        add(1, 0, 0, 0, 0, 0, 0, 0,              0, 'h55,  1, 1, 0, 0, 0, "st_done");
        // r1 alone is served
        add(1, 0, 0, 1, 'h7, 0, 0, 0,            0, 'h55,  1, 1, 0, 0, 0, "r1_req");
        add(1, 0, 0, 1, 'h7, 0, 0, 0,            1, 'h7,   1, 0, 0, 0, 1, "r1_acc");
        add(1, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D,  0, 'h7,   1, 1, 0, 1, 1, "r1_data");
        add(1, 0, 0, 0, 0, 0, 0, 0,              0, 'h7,   1, 1, 0, 0, 0, "r1_done");
        // reset returns address to zero and the round-robin pointer to its start
        add(0, 0, 0, 0, 0, 0, 0, 0,              0, 'h7,   1, 1, 0, 0, 0, "rst_assert");
        add(1, 0, 0, 0, 0, 0, 0, 0,              0, 0,     1, 1, 0, 0, 0, "rst_release");
        // both requesting continuously, one-cycle data latency
        pa = 0;
        for (int k = 0; k < 4; k++) begin
            w = RR ? (k % 2) : 0;
            a = (w != 0) ? 'h100 : 'h0;
            add(1, 1, 0, 1, 'h100, 0, 0, 0,            0, pa, 1, 1, 0, 0, 0, "both_idle");
            add(1, 1, 0, 1, 'h100, 0, 0, 0,            1, a,  w, 1 - w, 0, 0, 1, "both_acc");
            add(1, 1, 0, 1, 'h100, 0, 1, 32'hA0 + k,   0, a,  1, 1, 1 - w, w, 1, "both_data");
            pa = a;
        end
        add(1, 0, 0, 0, 0, 0, 0, 0,                    0, pa, 1, 1, 0, 0, 0, "both_done");

        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rs, tbl[i].r0r, tbl[i].r0a, tbl[i].r1r, tbl[i].r1a,
                tbl[i].fw, tbl[i].fv, tbl[i].fd);
            check($sformatf("%s[%0d]", tbl[i].nm, i), dut_outs(),
                  64'({tbl[i].efr, tbl[i].efa, tbl[i].e0w, tbl[i].e1w,
                       tbl[i].e0v, tbl[i].e1v, tbl[i].eb}));
            if (tbl[i].e0v) check($sformatf("%s_r0dat[%0d]", tbl[i].nm, i), 64'(r0_readdata), 64'(tbl[i].fd));
            if (tbl[i].e1v) check($sformatf("%s_r1dat[%0d]", tbl[i].nm, i), 64'(r1_readdata), 64'(tbl[i].fd));
        end

        // Reset while waiting for data; late data must never reach a requester.
        cyc(1'b1, 1'b1, 23'h20, 1'b0, 23'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 23'h20, 1'b0, 23'h0, 1'b0, 1'b0, 32'h0);
        check("rw_accept", 64'(r0_waitrequest), 64'd0);
        cyc(1'b1, 1'b0, 23'h0, 1'b0, 23'h0, 1'b0, 1'b0, 32'h0);
        check("rw_waiting", 64'({flash_mem_read, busy}), 64'b01);
        cyc(1'b0, 1'b0, 23'h0, 1'b0, 23'h0, 1'b0, 1'b0, 32'h0);
        for (int j = 0; j < 4; j++) begin
            cyc(1'b1, 1'b0, 23'h0, 1'b0, 23'h0, 1'b0, (j == 2) ? 1'b1 : 1'b0, 32'h0000_0BAD);
            check($sformatf("rw_after_reset[%0d]", j), dut_outs(), 64'({1'b0, 23'h0, 5'b11000}));
        end

        // Sequential load on r0, then randomized traffic on both requesters.
        mreq[0] = 1'b0;  mreq[1] = 1'b0;
        maddr[0] = '0;   maddr[1] = '0;
        m_free = 1'b1;  m_owner = 0;  m_acc = 1'b0;  m_last = 1;  m_addr = '0;
        pend_cnt = 0;   pend_dat = '0;
        engine(1'b1, 4000);
        engine(1'b0, 3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
